integrate_dump: RTL and testbench
=================================

Name: integrate_dump

Overview:
- Downstream consumer of the signed product stream from the multiplier stage in the demodulator datapath.
- Accumulates DUMP_LEN accepted products (integrate-and-dump correlator / matched-filter sum).
- Then rescales the sum with round-half-up and saturation, and presents one symbol-rate sample under valid/ready handshake.
- Supplies backpressure upstream when its single output register cannot be freed.

Parameters:
- IN_W, 40, signed input product width (A_DATA_W + B_DATA_W of producer)
- OUT_W, 24, signed output sample width
- DUMP_LEN, 16, products summed per output sample; legal range 2..1024
- SHIFT, 20, arithmetic right shift applied to sum before saturation; legal range 1..ACC_W-1
- ACC_W, IN_W+$clog2(DUMP_LEN), derived accumulator width; not overridden

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous reset, active-low (0 = reset)
- i_valid  in  1  upstream product valid
- i_prod  in  IN_W  signed product from multiplier
- i_clear  in  1  synchronous window restart (discard partial sum)
- i_ready  in  1  downstream ready for o_data
- o_ready  out  1  block accepts i_prod this cycle (combinational)
- o_data  out  OUT_W  signed dumped sample (registered)
- o_valid  out  1  o_data valid (registered)
- o_sat  out  1  o_data was saturated (registered, qualifies with o_valid)
- o_count  out  $clog2(DUMP_LEN)  products accumulated in current window (registered)

Behaviour:
- Reset (reset==0 at clk edge):
  - acc, o_count, o_data, o_valid, o_sat all cleared to 0.
  - Reset mid-window discards the partial sum and any pending output.
- Accept: a sample is consumed when i_valid && o_ready.
- o_ready = !(o_count==DUMP_LEN-1 && o_valid && !i_ready).
  - Only the window-closing sample stalls, and only while the output register is occupied and not being drained this cycle.
  - All other samples are always accepted.
- Non-final accept (o_count < DUMP_LEN-1): acc <= acc + sext(i_prod); o_count++.
- Final accept (o_count == DUMP_LEN-1):
  - sum = acc + sext(i_prod), computed at ACC_W bits, no overflow possible.
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up, toward +inf on ties). The rounding add is computed at ACC_W+1 bits.
  - If r > 2^(OUT_W-1)-1: o_data <= max, o_sat <= 1.
  - If r < -2^(OUT_W-1): o_data <= min, o_sat <= 1.
  - Otherwise o_data <= r[OUT_W-1:0], o_sat <= 0.
  - o_valid <= 1; acc <= 0; o_count <= 0.
  - Latency: o_valid rises on the edge after the final accept (1 cycle).
- Output drain: o_valid && i_ready consumes o_data.
  - o_valid goes to 0 next cycle unless a final accept occurs in the same cycle.
  - On a simultaneous final accept, o_valid stays 1 and o_data/o_sat take the new value.
- Hold: while o_valid && !i_ready, o_data and o_sat hold stable; accumulation of non-final samples continues.
- i_clear==1:
  - acc <= 0 and o_count <= 0. Any sample offered that cycle is ignored (clear wins).
  - o_ready is forced 0 during clear so upstream does not count it as consumed.
  - Output register and o_valid are unaffected; drain still occurs if i_ready.
- i_valid==0: acc and o_count hold.
- Reset wins over i_clear, accept and drain.
- i_prod is don't-care when not accepted.

Test Plan:
- Params IN_W=40, OUT_W=24, DUMP_LEN=4, SHIFT=2, i_ready=1. Feed 1,2,3,4 back-to-back.
  -> sum=10, o_data=3 ((10+2)>>2), o_sat=0.
  -> o_valid high exactly 1 cycle, starting one cycle after the 4th accept.
  -> o_count sequence 0,1,2,3,0.
- Same params, feed -5 x4.
  -> sum=-20, o_data=-5 ((-18)>>>2), o_sat=0.
  -> Also feed 1,1,0,0: sum=2, o_data=1 (tie rounds up).
- Same params, feed 2^30 x4.
  -> o_data=8388607, o_sat=1.
  -> Then feed -2^30 x4: o_data=-8388608, o_sat=1.
- Backpressure: complete one window with i_ready=0, then offer the next 4 samples continuously.
  -> First 3 accepted; 4th sees o_ready=0 and o_data holds.
  -> Raise i_ready: 4th accepted that cycle, o_valid stays 1, and o_data updates to the new sum next cycle.
  -> No sample lost or duplicated (scoreboard against a reference model).
- Clear and reset mid-window:
  - Accept 7,7, then pulse i_clear with i_valid=1 and value 100 (not consumed, o_ready=0), then feed 1,1,1,1 -> o_data=1.
  - Separately, accept 2 samples, assert reset for 1 cycle -> o_valid=0, o_count=0, and the next full window of 4,4,4,4 gives o_data=4.

Source files
------------

// File: rtl/integrate_dump.sv
// Integrate-and-dump correlator: sums DUMP_LEN signed products, then rescales
// the sum with round-half-up and saturation into one handshaked output sample.
module integrate_dump #(
  parameter int IN_W     = 40,
  parameter int OUT_W    = 24,
  parameter int DUMP_LEN = 16,
  parameter int SHIFT    = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_valid,
  input  logic [IN_W-1:0]             i_prod,
  input  logic                        i_clear,
  input  logic                        i_ready,
  output logic                        o_ready,
  output logic [OUT_W-1:0]            o_data,
  output logic                        o_valid,
  output logic                        o_sat,
  output logic [$clog2(DUMP_LEN)-1:0] o_count
);

  localparam int CNT_W = $clog2(DUMP_LEN);
  localparam int ACC_W = IN_W + CNT_W;

  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(DUMP_LEN - 1);
  localparam logic signed [ACC_W:0]   ROUND    = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0]   SAT_MAX  = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0]   SAT_MIN  = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [OUT_W-1:0]        OUT_MAX  = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN  = {1'b1, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   scaled;
  logic [CNT_W-1:0]        count_nxt;
  logic [OUT_W-1:0]        data_nxt;
  logic                    sat_nxt;
  logic                    valid_nxt;
  logic                    last;
  logic                    accept;
  logic                    final_accept;
  logic                    drain;

  // Only the window-closing sample can stall, and clear cycles never consume.
  assign last         = (o_count == LAST_IDX);
  assign o_ready      = !i_clear && !(last && o_valid && !i_ready);
  assign accept       = i_valid && o_ready;
  assign final_accept = accept && last;
  assign drain        = o_valid && i_ready;

  assign sum     = acc + {{CNT_W{i_prod[IN_W-1]}}, i_prod};
  assign rounded = {sum[ACC_W-1], sum} + ROUND;
  assign scaled  = rounded >>> SHIFT;

  always_comb begin
    acc_nxt   = acc;
    count_nxt = o_count;
    data_nxt  = o_data;
    sat_nxt   = o_sat;
    valid_nxt = o_valid;

    if (drain) valid_nxt = 1'b0;

    if (i_clear) begin
      acc_nxt   = '0;
      count_nxt = '0;
    end else if (final_accept) begin
      acc_nxt   = '0;
      count_nxt = '0;
      valid_nxt = 1'b1;
      if (scaled > SAT_MAX) begin
        data_nxt = OUT_MAX;
        sat_nxt  = 1'b1;
      end else if (scaled < SAT_MIN) begin
        data_nxt = OUT_MIN;
        sat_nxt  = 1'b1;
      end else begin
        data_nxt = scaled[OUT_W-1:0];
        sat_nxt  = 1'b0;
      end
    end else if (accept) begin
      acc_nxt   = sum;
      count_nxt = o_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc     <= '0;
      o_count <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      o_count <= count_nxt;
      o_data  <= data_nxt;
      o_valid <= valid_nxt;
      o_sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_integrate_dump.sv
// Scoreboard bench for integrate_dump with DUMP_LEN=4, SHIFT=2: directed windows
// push hand-computed samples, a negedge monitor pops them on each output transfer.
module tb_integrate_dump;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [39:0] i_prod;
  logic        i_clear;
  logic        i_ready;
  logic        o_ready;
  logic [23:0] o_data;
  logic        o_valid;
  logic        o_sat;
  logic [1:0]  o_count;

  typedef struct {
    logic signed [23:0] data;
    logic               sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_item;
  int   checks   = 0;
  int   failures = 0;

  integrate_dump #(
    .IN_W(40), .OUT_W(24), .DUMP_LEN(4), .SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_prod(i_prod),
    .i_clear(i_clear), .i_ready(i_ready), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .o_sat(o_sat), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input longint data, input logic sat);
    exp_t e;
    e.data = data[23:0];
    e.sat  = sat;
    exp_q.push_back(e);
  endtask

  // Offer one product and hold it until the DUT accepts it (bounded wait).
  task automatic applyStimulus(input longint prod);
    int n;
    i_valid = 1'b1;
    i_prod  = prod[39:0];
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic feedWindow(input longint a, input longint b, input longint c, input longint d);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
    applyStimulus(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each output transfer (o_valid && i_ready at the following edge) pops one entry.
  always @(negedge clk) begin
    if (reset && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 0, 1);
      end else begin
        mon_item = exp_q.pop_front();
        checkOutput("o_data", $signed(o_data), mon_item.data);
        checkOutput("o_sat", o_sat, mon_item.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    i_valid = 1'b0;
    i_prod  = '0;
    i_clear = 1'b0;
    i_ready = 1'b1;
    idle(3);
    reset = 1'b1;

    checkOutput("reset_o_valid", o_valid, 0);
    checkOutput("reset_o_count", o_count, 0);
    checkOutput("reset_o_data", $signed(o_data), 0);
    checkOutput("reset_o_sat", o_sat, 0);

    // Basic window 1,2,3,4: (10+2)>>2 = 3, with count and latency tracking
    $display("[TB] basic window");
    pushExpected(3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("count_seq", o_count, k);
      applyStimulus(k + 1);
    end
    checkOutput("valid_after_final", o_valid, 1);
    checkOutput("count_wrap", o_count, 0);
    idle(1);
    checkOutput("valid_one_cycle", o_valid, 0);

    $display("[TB] negative and tie rounding");
    pushExpected(-5, 1'b0);
    feedWindow(-5, -5, -5, -5);
    pushExpected(1, 1'b0);
    feedWindow(1, 1, 0, 0);
    idle(2);

    $display("[TB] saturation");
    pushExpected(8388607, 1'b1);
    feedWindow(64'sd1 <<< 30, 64'sd1 <<< 30, 64'sd1 <<< 30, 64'sd1 <<< 30);
    pushExpected(-8388608, 1'b1);
    feedWindow(-(64'sd1 <<< 30), -(64'sd1 <<< 30), -(64'sd1 <<< 30), -(64'sd1 <<< 30));
    idle(2);

    // Backpressure: first window parked, next window's closing sample stalls
    $display("[TB] backpressure");
    i_ready = 1'b0;
    pushExpected(10, 1'b0);
    feedWindow(10, 10, 10, 10);
    checkOutput("bp_valid", o_valid, 1);
    applyStimulus(20);
    applyStimulus(20);
    applyStimulus(20);
    checkOutput("bp_count", o_count, 3);
    checkOutput("bp_hold_data", $signed(o_data), 10);
    i_valid = 1'b1;
    i_prod  = 40'd20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_stall_ready", o_ready, 0);
      checkOutput("bp_stall_data", $signed(o_data), 10);
      checkOutput("bp_stall_valid", o_valid, 1);
    end
    @(posedge clk);
    #1;
    pushExpected(20, 1'b0);
    i_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", o_ready, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    checkOutput("bp_valid_stays", o_valid, 1);
    checkOutput("bp_new_data", $signed(o_data), 20);
    checkOutput("bp_count_wrap", o_count, 0);
    idle(2);

    $display("[TB] clear mid-window");
    applyStimulus(7);
    applyStimulus(7);
    i_valid = 1'b1;
    i_prod  = 40'd100;
    i_clear = 1'b1;
    @(negedge clk);
    checkOutput("clear_ready", o_ready, 0);
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    checkOutput("clear_count", o_count, 0);
    pushExpected(1, 1'b0);
    feedWindow(1, 1, 1, 1);
    idle(2);

    $display("[TB] reset mid-window");
    applyStimulus(4);
    applyStimulus(4);
    checkOutput("pre_reset_count", o_count, 2);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    checkOutput("post_reset_valid", o_valid, 0);
    checkOutput("post_reset_count", o_count, 0);
    pushExpected(4, 1'b0);
    feedWindow(4, 4, 4, 4);
    idle(3);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
